// File: rtl/datamem_pkg.sv
// Shared types and helpers for the byte-addressed data memory: FSM states,
// transfer-size legality and lane byte-enable generation.
package datamem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_WB = 8;

  // Size must be a non-zero power of two no wider than one word.
  function automatic logic size_legal(input logic [3:0] size, input int unsigned word_bytes);
    return (size != 4'd0) && ((size & (size - 4'd1)) == 4'd0) && (32'(size) <= word_bytes);
  endfunction

  // Byte enables within the word lane; an aligned transfer never crosses a word.
  function automatic logic [MAX_WB-1:0] byte_mask(input logic [63:0] addr, input logic [3:0] size,
                                                  input int unsigned word_bytes);
    logic [15:0] m;
    logic [2:0]  off;
    off = 3'(addr) & 3'(word_bytes - 1);
    m   = ((16'd1 << size) - 16'd1) << off;
    return m[MAX_WB-1:0];
  endfunction

endpackage

// File: rtl/datamem_chk.sv
// Per-port request checker: legality (size, alignment, range) and lane byte mask.
module datamem_chk
  import datamem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WORD_BYTES  = 8
) (
  input  logic [63:0]           i_addr,
  input  logic [3:0]            i_size,
  output logic                  o_legal,
  output logic [WORD_BYTES-1:0] o_mask
);

  logic [64:0]       w_end;
  logic [MAX_WB-1:0] w_mask_full;

  // 65-bit sum so addresses near 2^64 cannot wrap into range.
  assign w_end       = {1'b0, i_addr} + 65'(i_size);
  assign o_legal     = size_legal(i_size, WORD_BYTES) &&
                       ((i_addr & 64'(i_size - 4'd1)) == 64'd0) &&
                       (w_end <= 65'(DEPTH_BYTES));
  assign w_mask_full = byte_mask(i_addr, i_size, WORD_BYTES);
  assign o_mask      = w_mask_full[WORD_BYTES-1:0];

endmodule

// File: rtl/datamem_pipe.sv
// Byte-addressed data memory with one load and one store port per cycle,
// 1-cycle load latency, write-first forwarding and a zero-fill init sweep.
module datamem_pipe
  import datamem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WORD_BYTES  = 8,
  parameter int TAG_W       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  output logic                    init_done,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [63:0]             ld_addr,
  input  logic [3:0]              ld_size,
  input  logic [TAG_W-1:0]        ld_tag,
  output logic                    rsp_valid,
  output logic [8*WORD_BYTES-1:0] rsp_data,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    rsp_err,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [63:0]             st_addr,
  input  logic [3:0]              st_size,
  input  logic [8*WORD_BYTES-1:0] st_data,
  output logic                    st_err
);

  localparam int NWORDS = DEPTH_BYTES / WORD_BYTES;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam int ABITS  = $clog2(DEPTH_BYTES);
  localparam int OFF_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int DW     = 8 * WORD_BYTES;

  logic [7:0] r_mem [DEPTH_BYTES];

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic              r_rsp_valid, r_rsp_err, r_st_err;
  logic [DW-1:0]     r_rsp_data;
  logic [TAG_W-1:0]  r_rsp_tag;

  logic                  w_rdy, w_ld_acc, w_st_acc, w_st_we;
  logic                  w_ld_legal, w_st_legal;
  logic [WORD_BYTES-1:0] w_ld_mask, w_st_mask;
  logic [ABITS-1:0]      w_ld_base, w_st_base, w_init_base;
  logic [OFF_W-1:0]      w_ld_off, w_st_off;
  logic [DW-1:0]         w_st_lanes, w_rd_lanes, w_ld_shift, w_ld_data;

  datamem_chk #(.DEPTH_BYTES(DEPTH_BYTES), .WORD_BYTES(WORD_BYTES)) u_chk_ld (
    .i_addr(ld_addr), .i_size(ld_size), .o_legal(w_ld_legal), .o_mask(w_ld_mask)
  );
  datamem_chk #(.DEPTH_BYTES(DEPTH_BYTES), .WORD_BYTES(WORD_BYTES)) u_chk_st (
    .i_addr(st_addr), .i_size(st_size), .o_legal(w_st_legal), .o_mask(w_st_mask)
  );

  assign w_rdy     = (r_state == RUN) & ~clear;
  assign ld_ready  = w_rdy;
  assign st_ready  = w_rdy;
  assign init_done = (r_state == RUN);
  assign w_ld_acc  = ld_valid & w_rdy;
  assign w_st_acc  = st_valid & w_rdy;
  assign w_st_we   = w_st_acc & w_st_legal;

  assign w_ld_base   = ABITS'(ld_addr) & ~ABITS'(WORD_BYTES - 1);
  assign w_st_base   = ABITS'(st_addr) & ~ABITS'(WORD_BYTES - 1);
  assign w_ld_off    = OFF_W'(ld_addr) & OFF_W'(WORD_BYTES - 1);
  assign w_st_off    = OFF_W'(st_addr) & OFF_W'(WORD_BYTES - 1);
  assign w_init_base = ABITS'(r_idx) << $clog2(WORD_BYTES);
  assign w_st_lanes  = st_data << {w_st_off, 3'b000};

  // Both transfers sit inside one word, so overlap means same word base.
  always_comb begin
    w_rd_lanes = '0;
    w_ld_data  = '0;
    for (int j = 0; j < WORD_BYTES; j++) begin
      w_rd_lanes[8*j +: 8] = r_mem[w_ld_base + ABITS'(j)];
      if (w_st_we && (w_st_base == w_ld_base) && w_st_mask[j] && w_ld_mask[j])
        w_rd_lanes[8*j +: 8] = w_st_lanes[8*j +: 8];
    end
    w_ld_shift = w_rd_lanes >> {w_ld_off, 3'b000};
    for (int j = 0; j < WORD_BYTES; j++)
      if (j < int'(ld_size)) w_ld_data[8*j +: 8] = w_ld_shift[8*j +: 8];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      INIT: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == IDX_W'(NWORDS - 1)) begin
          w_state_nxt = RUN;
          w_idx_nxt   = '0;
        end
      end
      RUN: if (clear) begin
        w_state_nxt = INIT;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= INIT;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_st_err    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_rsp_valid <= w_ld_acc;
      r_rsp_err   <= w_ld_acc & ~w_ld_legal;
      r_st_err    <= w_st_acc & ~w_st_legal;
      if (w_ld_acc) begin
        r_rsp_tag  <= ld_tag;
        r_rsp_data <= w_ld_legal ? w_ld_data : '0;
      end
    end
  end

  // Storage has no reset; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      for (int b = 0; b < WORD_BYTES; b++)
        r_mem[w_init_base + ABITS'(b)] <= 8'h00;
    end else if (w_st_we) begin
      for (int j = 0; j < WORD_BYTES; j++)
        if (w_st_mask[j]) r_mem[w_st_base + ABITS'(j)] <= w_st_lanes[8*j +: 8];
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_rsp_tag;
  assign st_err    = r_st_err;

endmodule

// File: tb/tb_datamem_pipe.sv
// Table-driven bench for datamem_pipe with a response scoreboard and
// hand-written clear / reset-abort sequences.
module tb_datamem_pipe;

  logic        clk, reset, clear;
  logic        init_done, ld_valid, ld_ready, st_valid, st_ready;
  logic [63:0] ld_addr, st_addr, st_data, rsp_data;
  logic [3:0]  ld_size, st_size, ld_tag, rsp_tag;
  logic        rsp_valid, rsp_err, st_err;

  datamem_pipe #(.DEPTH_BYTES(1024), .WORD_BYTES(8), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .init_done(init_done),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_tag(ld_tag), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_size(st_size), .st_data(st_data), .st_err(st_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [63:0] sa;
    logic [3:0]  ss;
    logic [63:0] sd;
    bit          ld;
    logic [63:0] la;
    logic [3:0]  ls;
    logic [63:0] ed;
    bit          ee;
    bit          ese;
  } vec_t;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;
  vec_t tv[18];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Every response must arrive exactly one cycle after its load was accepted.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("rsp_tag", {60'd0, rsp_tag}, {60'd0, e.tag});
      check("rsp_data", rsp_data, e.data);
      check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
    end else if (rsp_valid !== 1'b0) begin
      check("rsp_valid_idle", {63'd0, rsp_valid}, 64'd0);
    end
  end

  task automatic apply(input vec_t v, input logic [3:0] tag);
    exp_t e;
    st_valid = v.st; st_addr = v.sa; st_size = v.ss; st_data = v.sd;
    ld_valid = v.ld; ld_addr = v.la; ld_size = v.ls; ld_tag = tag;
    if (v.ld) begin
      check("ld_ready", {63'd0, ld_ready}, 64'd1);
      if (ld_ready) begin
        e.tag = tag; e.data = v.ed; e.err = v.ee; e.due = cyc + 1;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    check("st_err", {63'd0, st_err}, {63'd0, v.st & v.ese});
  endtask

  task automatic idle(input int n);
    st_valid = 1'b0; ld_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic ld_zero(input logic [63:0] a, input logic [3:0] tag);
    vec_t v;
    v = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, a, 4'd8, 64'h0, 1'b0, 1'b0};
    apply(v, tag);
  endtask

  task automatic reset_vals(input string name);
    check({name, "_flags"}, {58'd0, init_done, ld_ready, st_ready, rsp_valid, rsp_err, st_err}, 64'd0);
    check({name, "_data"}, rsp_data, 64'd0);
    check({name, "_tag"}, {60'd0, rsp_tag}, 64'd0);
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n), 64'd128);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{1'b1, 64'h10, 4'd8, 64'h1122334455667788, 1'b0, 64'h0, 4'd0, 64'h0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, 64'h12, 4'd2, 64'h5566, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, 64'h10, 4'd8, 64'h1122334455667788, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, 64'h17, 4'd1, 64'h11, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 64'h21, 4'd1, 64'hAB, 1'b1, 64'h20, 4'd4, 64'h0000AB00, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, 64'h20, 4'd4, 64'h0000AB00, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 64'h13, 4'd4, 64'hDEADBEEF, 1'b0, 64'h0, 4'd0, 64'h0, 1'b0, 1'b1};
    tv[7]  = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, 64'h10, 4'd8, 64'h1122334455667788, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, 64'h3FC, 4'd8, 64'h0, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, 64'h3F8, 4'd8, 64'h0, 1'b0, 1'b0};
    tv[10] = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, 64'h0, 4'd3, 64'h0, 1'b1, 1'b0};
    tv[11] = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, 64'h400, 4'd1, 64'h0, 1'b1, 1'b0};
    tv[12] = '{1'b1, 64'h30, 4'd2, 64'hFFFFFFFFFFFFBEEF, 1'b1, 64'h3FF, 4'd1, 64'h0, 1'b0, 1'b0};
    tv[13] = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, 64'h30, 4'd8, 64'hBEEF, 1'b0, 1'b0};
    tv[14] = '{1'b1, 64'h38, 4'd8, 64'hA1A2A3A4A5A6A7A8, 1'b1, 64'h38, 4'd8, 64'hA1A2A3A4A5A6A7A8, 1'b0, 1'b0};
    tv[15] = '{1'b1, 64'h3A, 4'd2, 64'h5566, 1'b1, 64'h38, 4'd8, 64'hA1A2A3A45566A7A8, 1'b0, 1'b0};
    tv[16] = '{1'b0, 64'h0, 4'd0, 64'h0, 1'b1, 64'hFFFFFFFFFFFFFFF8, 4'd8, 64'h0, 1'b1, 1'b0};
    tv[17] = '{1'b1, 64'h08, 4'd0, 64'h1, 1'b1, 64'h08, 4'd8, 64'h0, 1'b0, 1'b1};

    reset = 1'b1; clear = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_size = '0; ld_tag = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset_vals("rst");
    reset = 1'b1;
    wait_init("init_cycles");

    ld_zero(64'h0, 4'd1);
    ld_zero(64'h3F8, 4'd2);

    for (int i = 0; i < 18; i++) apply(tv[i], 4'(i));
    idle(2);
    check("sb_drain", 64'(sb.size()), 64'd0);

    // clear in RUN: ready drops at once, full sweep, memory reads zero
    clear = 1'b1;
    #1;
    check("clear_ready", {62'd0, ld_ready, st_ready}, 64'd0);
    @(negedge clk);
    clear = 1'b0;
    wait_init("clear_init_cycles");
    ld_zero(64'h10, 4'd3);
    ld_zero(64'h38, 4'd4);
    ld_zero(64'h20, 4'd5);
    ld_zero(64'h30, 4'd6);
    idle(2);

    // reset while a response is in flight drops it
    apply('{1'b1, 64'h48, 4'd8, 64'hCAFEF00DCAFEF00D, 1'b0, 64'h0, 4'd0, 64'h0, 1'b0, 1'b0}, 4'd0);
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 64'h48; ld_size = 4'd8; ld_tag = 4'd9;
    @(posedge clk);
    #1;
    check("inflight_data", rsp_data, 64'hCAFEF00DCAFEF00D);
    ld_valid = 1'b0;
    reset = 1'b0;
    #1;
    reset_vals("rst_inflight");
    @(negedge clk);
    reset = 1'b1;

    // reset 40 cycles into INIT restarts the full sweep
    repeat (40) @(negedge clk);
    check("mid_init_done", {63'd0, init_done}, 64'd0);
    reset = 1'b0;
    #1;
    reset_vals("rst_mid_init");
    @(negedge clk);
    reset = 1'b1;
    wait_init("reinit_cycles");
    ld_zero(64'h48, 4'd7);
    ld_zero(64'h3F8, 4'd8);
    idle(2);
    check("sb_final", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/datamem_pipe.md
DATAMEM_PIPE -- requirements
Module: datamem_pipe

Interface
REQ-001 Parameter DEPTH_BYTES, 1024, memory size in bytes; power of two, at least 2*WORD_BYTES.
REQ-002 Parameter WORD_BYTES, 8, maximum transfer size in bytes and init-clear granularity; power of two, 1..8.
REQ-003 Parameter TAG_W, 4, width of the load tag returned with each response.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 clear  in  1  synchronous request to re-zero the whole memory.
REQ-007 init_done  out  1  high when the memory is usable (state RUN).
REQ-008 ld_valid / ld_ready  in / out  1 / 1  load request handshake.
REQ-009 ld_addr, ld_size, ld_tag  in  64, 4, TAG_W  load byte address, size in bytes, and tag.
REQ-010 rsp_valid, rsp_data, rsp_tag, rsp_err  out  1, 8*WORD_BYTES, TAG_W, 1  load response.
REQ-011 st_valid / st_ready  in / out  1 / 1  store request handshake.
REQ-012 st_addr, st_size, st_data  in  64, 4, 8*WORD_BYTES  store byte address, size in bytes, and data.
REQ-013 st_err  out  1  one-cycle pulse: the accepted store was rejected.

Function
REQ-014 Storage shall be little-endian: byte k of a transfer maps to address addr+k and to data bits [8k+7:8k].
REQ-015 The FSM shall have two states. INIT writes one zero word per cycle at an incrementing word index; when the last index (DEPTH_BYTES/WORD_BYTES-1) is written, it goes to RUN.
REQ-016 In RUN, clear=1 shall move the FSM to INIT with the index at 0; clear is ignored in INIT.
REQ-017 ld_ready and st_ready shall both equal (state==RUN) & ~clear.
REQ-018 A request is legal when all three hold: size is in {1,2,4,...,WORD_BYTES}; addr is a multiple of size; addr+size <= DEPTH_BYTES. Silent address re-alignment is not allowed.
REQ-019 An accepted legal store shall write exactly size bytes at the clock edge of acceptance.
REQ-020 An accepted illegal store shall write nothing and pulse st_err in the next cycle.
REQ-021 Load latency shall be 1: acceptance in cycle N gives rsp_valid=1 for one cycle in N+1, with rsp_tag equal to the accepted ld_tag.
REQ-022 rsp_data bytes at or above size shall be zero, never X.
REQ-023 An illegal load shall return rsp_err=1 and rsp_data=0.
REQ-024 A load and a store accepted in the same cycle with overlapping bytes shall see the new store data on the overlapping bytes (write-first, per byte). Non-overlapping bytes return prior contents.
REQ-025 Stores and loads to the same address in consecutive cycles shall be coherent without stalls.
REQ-026 The responder has no backpressure; the block shall sustain one load and one store per cycle.

Reset
REQ-027 While reset=0: state=INIT, index=0, init_done=0, ld_ready=0, st_ready=0, rsp_valid=0, rsp_err=0, st_err=0, rsp_data=0, rsp_tag=0.
REQ-028 After reset is released, the memory shall read all-zero once init_done first rises, DEPTH_BYTES/WORD_BYTES cycles later.
REQ-029 Reset asserted mid-INIT or mid-transfer shall abort that operation; a response in flight is dropped (rsp_valid=0).

Structure
REQ-030 Package datamem_pkg shall hold: the state enum (INIT, RUN); a function returning size legality; a function returning a byte-enable mask from addr and size.
REQ-031 Sub-module datamem_chk shall compute legality and the byte mask, instantiated once per port.
REQ-032 Storage shall be a byte array written only in the single clocked process.

Verification
REQ-033 Release reset -> init_done rises after exactly 128 cycles (defaults); loads to 0x0 and 0x3F8 (size 8) return 0.
REQ-034 Store 0x1122334455667788 at 0x10 size 8, then load 0x12 size 2 -> rsp_data=0x5566, rsp_err=0, upper bytes 0.
REQ-035 In the same cycle: store 0xAB at 0x21 size 1, and load 0x20 size 4 over prior contents 0 -> rsp_data=0x0000AB00.
REQ-036 Store at 0x13 size 4, and separately load at 0x3FC size 8 -> st_err pulse with memory unchanged; rsp_err=1 with rsp_data=0.
REQ-037 Assert clear in RUN after writes -> ready drops, INIT runs 128 cycles, then all loads read 0.
REQ-038 Assert reset at cycle 40 of INIT -> outputs at reset values; the full 128-cycle INIT restarts after release.
